usb_ep_buf: RTL and testbench
=============================

# usb_ep_buf

Per-endpoint byte buffer between the USB function core's endpoint port (ep_cfg, ep_din, ep_dout, ep_we, ep_re, ep_empty, ep_full, ep_bf_en, ep_bf_size) and the application. It is a single synchronous FIFO whose producer and consumer sides are selected by the endpoint direction. It reports occupancy and free-space chunk size back to the core, and flags overflow and underflow. One instance is built per endpoint, ep1 to ep7.

## Interface
- DEPTH, 64: FIFO bytes; power of two, 4..128.
- EP_CFG, 14'h0800: constant driven on ep_cfg. EP_CFG[11:10] is the direction: 2'b01 means IN (app→core), 2'b10 means OUT (core→app). Any other code disables both sides.
- BF_EN, 1: value driven on ep_bf_en.
- Ports:
  - clk  in  1  endpoint clock; the only clock.
  - rst  in  1  reset, asynchronous, active-low.
  - flush  in  1  synchronous buffer clear.
  - ep_cfg  out  14  endpoint configuration to the core.
  - ep_din  out  8  IN data to the core; first-word-fall-through.
  - ep_re  in  1  core read strobe (IN).
  - ep_dout  in  8  OUT data from the core.
  - ep_we  in  1  core write strobe (OUT).
  - ep_empty  out  1  no byte available to the core (IN), else 1.
  - ep_full  out  1  no space for the core (OUT), else 1.
  - ep_bf_en  out  1  buffer-size reporting enable.
  - ep_bf_size  out  7  IN: occupancy; OUT: free space. Saturated at 127.
  - app_wdata  in  8  IN data from the application.
  - app_we  in  1  application write strobe.
  - app_rdata  out  8  OUT data to the application; first-word-fall-through.
  - app_re  in  1  application read strobe.
  - app_level  out  log2(DEPTH)+1  occupancy.
  - err_ovf  out  1  sticky: a write arrived while full.
  - err_unf  out  1  sticky: a read arrived while empty.
  - err_clr  in  1  clears err_ovf, err_unf and drop_cnt.
  - drop_cnt  out  8  dropped-write count.

## Operation
- Storage and pointers:
  - Storage is a DEPTH×8 array.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- Side selection by direction:
  - IN: producer is app_we/app_wdata; consumer is ep_re/ep_din.
  - OUT: producer is ep_we/ep_dout; consumer is app_re/app_rdata.
  - Strobes on the unselected side are ignored and raise no error.
  - Invalid direction: all strobes ignored; ep_empty=1, ep_full=1.
- Write:
  - Accepted iff producer strobe=1 and count<DEPTH. The byte goes to mem[wr_ptr] and wr_ptr increments.
  - A write while full is dropped: err_ovf is set and drop_cnt increments. This holds even if a read occurs in the same cycle.
- Read:
  - Accepted iff consumer strobe=1 and count>0; rd_ptr increments.
  - A read while empty sets err_unf and changes no state.
  - The read data port always shows mem[rd_ptr]. It is undefined-but-stable when empty.
- Accepted read and write in the same cycle: count unchanged. Empty plus both strobes: the write is accepted, the read is an underflow.
- Flush:
  - Zeroes wr_ptr, rd_ptr and count in one cycle and overrides strobes that cycle.
  - Error flags are not cleared by flush.
- err_clr: if an error event occurs in the same cycle, the new event wins (flag ends 1).
- drop_cnt saturates at 255.
- Flag and size derivation:
  - ep_empty = (count==0).
  - ep_full = (count==DEPTH).
  - ep_bf_size = IN ? min(count,127) : min(DEPTH−count,127).
- Constant outputs: ep_cfg=EP_CFG and ep_bf_en=BF_EN.

## Timing
- Reset (rst low, asynchronous):
  - Pointers, count, app_level=0 and drop_cnt=0.
  - ep_empty=1 and err_ovf=err_unf=0.
  - ep_full=0 for a valid direction, 1 for invalid.
  - ep_bf_size=0 (IN) or min(DEPTH,127) (OUT).
  - Release is synchronous to clk.
- count, flags, app_level, ep_bf_size and the error outputs are registered. They update on the clock edge after the strobe.
- Write-to-read latency is 1 cycle: a byte written at edge N is readable by the consumer in cycle N+1.
- Read data is valid in the same cycle the consumer samples it, before asserting the strobe (FWFT). After an accepted read, the next byte appears one cycle later.
- Full and empty flags must never lag a back-to-back strobe stream. A strobe in the cycle after count reaches DEPTH or 0 is treated as overflow or underflow.
- The core samples through its clocking block, so all outputs are glitch-free flops.

## Configuration
- USB_EP_BUF_ERR_EN:
  - Defined: err_ovf, err_unf and drop_cnt are implemented as above.
  - Undefined: those outputs are tied to 0, err_clr is ignored, and the error logic is removed. Data-path behaviour is identical.

## Test plan
- OUT, DEPTH=64: core writes 0x00..0x3F back-to-back → ep_full=1 one cycle after the 64th write; app reads back 0x00..0x3F in order; ep_empty/app_level return to 0.
- IN: app writes 10 bytes → ep_bf_size=10 and ep_empty=0 one cycle later; core reads 10 → ep_bf_size=0, ep_empty=1; no errors.
- OUT full: a 65th write with a simultaneous app_re → write dropped, err_ovf=1, drop_cnt=1, count=63.
- Empty read: app_re with a simultaneous ep_we → count=1 and err_unf=1. err_clr together with a new underflow → err_unf stays 1.
- Wrap and flush: 200 random interleaved IN transfers, checked against a scoreboard. Flush mid-stream → count=0 next cycle and errors retained. Asserting rst low mid-write → outputs take their reset values immediately.
- Build without USB_EP_BUF_ERR_EN: repeat the overflow test → err_ovf=0, drop_cnt=0, data identical.

Source files
------------

// File: rtl/usb_ep_buf.sv
// usb_ep_buf: per-endpoint FWFT byte FIFO between USB core and application, direction from EP_CFG[11:10].
// Define USB_EP_BUF_ERR_EN to build the sticky overflow/underflow flags and the dropped-write counter.
module usb_ep_buf #(
  parameter int DEPTH = 64,
  parameter logic [13:0] EP_CFG = 14'h0800,
  parameter logic BF_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  output logic [13:0]             ep_cfg,
  output logic [7:0]              ep_din,
  input  logic                    ep_re,
  input  logic [7:0]              ep_dout,
  input  logic                    ep_we,
  output logic                    ep_empty,
  output logic                    ep_full,
  output logic                    ep_bf_en,
  output logic [6:0]              ep_bf_size,
  input  logic [7:0]              app_wdata,
  input  logic                    app_we,
  output logic [7:0]              app_rdata,
  input  logic                    app_re,
  output logic [$clog2(DEPTH):0]  app_level,
  output logic                    err_ovf,
  output logic                    err_unf,
  input  logic                    err_clr,
  output logic [7:0]              drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DV = (AW+1)'(DEPTH);
  localparam logic IS_IN = EP_CFG[11:10] == 2'b01;
  localparam logic IS_OUT = EP_CFG[11:10] == 2'b10;
  localparam logic VALID = IS_IN | IS_OUT;

  function automatic logic [6:0] sat7(input logic [7:0] v);
    return v[7] ? 7'h7f : v[6:0];
  endfunction

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic          r_empty, r_full;
  logic [6:0]    r_bfsz;
  logic [7:0]    r_rdata;

  logic          w_pst, w_cst, w_wacc, w_racc, w_ovf, w_unf;
  logic [7:0]    w_wdata;
  logic [AW:0]   w_count;
  logic [AW-1:0] w_wr_nxt, w_rd_nxt;

  always_comb begin
    w_pst    = IS_IN ? app_we : IS_OUT ? ep_we : 1'b0;
    w_cst    = IS_IN ? ep_re : IS_OUT ? app_re : 1'b0;
    w_wdata  = IS_IN ? app_wdata : ep_dout;
    w_wacc   = w_pst & (r_count != DV) & ~flush;
    w_racc   = w_cst & (r_count != '0) & ~flush;
    w_ovf    = w_pst & (r_count == DV) & ~flush;
    w_unf    = w_cst & (r_count == '0) & ~flush;
    w_count  = flush ? '0 : r_count + (AW+1)'(w_wacc) - (AW+1)'(w_racc);
    w_wr_nxt = flush ? '0 : r_wr + AW'(w_wacc);
    w_rd_nxt = flush ? '0 : r_rd + AW'(w_racc);
  end

  always_ff @(posedge clk)
    if (w_wacc) r_mem[r_wr] <= w_wdata;

  // Read data is a flop holding the next head; bypass the incoming byte when it becomes the head.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= ~VALID;
      r_bfsz  <= IS_IN ? 7'd0 : sat7(8'(DEPTH));
      r_rdata <= '0;
    end else begin
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_count <= w_count;
      r_empty <= VALID ? (w_count == '0) : 1'b1;
      r_full  <= VALID ? (w_count == DV) : 1'b1;
      r_bfsz  <= IS_IN ? sat7(8'(w_count)) : sat7(8'(DV - w_count));
      r_rdata <= (w_wacc && r_wr == w_rd_nxt) ? w_wdata : r_mem[w_rd_nxt];
    end

`ifdef USB_EP_BUF_ERR_EN
  logic       r_ovf, r_unf;
  logic [7:0] r_drop;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_drop <= '0;
    end else begin
      r_ovf  <= (r_ovf & ~err_clr) | w_ovf;
      r_unf  <= (r_unf & ~err_clr) | w_unf;
      r_drop <= err_clr ? {7'd0, w_ovf} : (w_ovf && r_drop != 8'hff) ? r_drop + 8'd1 : r_drop;
    end
  assign err_ovf  = r_ovf;
  assign err_unf  = r_unf;
  assign drop_cnt = r_drop;
`else
  logic w_unused;
  assign w_unused = err_clr ^ w_ovf ^ w_unf;
  assign err_ovf  = 1'b0;
  assign err_unf  = 1'b0;
  assign drop_cnt = '0;
`endif

  assign ep_cfg     = EP_CFG;
  assign ep_bf_en   = BF_EN;
  assign ep_din     = r_rdata;
  assign app_rdata  = r_rdata;
  assign ep_empty   = r_empty;
  assign ep_full    = r_full;
  assign ep_bf_size = r_bfsz;
  assign app_level  = r_count;
endmodule

// File: tb/tb_usb_ep_buf.sv
// tb_usb_ep_buf: scoreboard bench for usb_ep_buf with OUT, IN and invalid-direction instances sharing stimulus.
module tb_usb_ep_buf;
  localparam int DEPTH = 64;
`ifdef USB_EP_BUF_ERR_EN
  localparam int ERR = 1;
`else
  localparam int ERR = 0;
`endif

  logic clk = 0, rst = 0, flush = 0, ep_re = 0, ep_we = 0, app_we = 0, app_re = 0, err_clr = 0;
  logic [7:0] ep_dout = 0, app_wdata = 0;

  logic [13:0] o_cfg, i_cfg, b_cfg;
  logic [7:0]  o_din, i_din, b_din, o_rdata, i_rdata, b_rdata, o_drop, i_drop, b_drop;
  logic        o_empty, i_empty, b_empty, o_full, i_full, b_full, o_bfen, i_bfen, b_bfen;
  logic        o_ovf, i_ovf, b_ovf, o_unf, i_unf, b_unf;
  logic [6:0]  o_bfsz, i_bfsz, b_bfsz, o_level, i_level, b_level;

  usb_ep_buf #(.DEPTH(DEPTH), .EP_CFG(14'h0800)) u_out (
    .clk(clk), .rst(rst), .flush(flush), .ep_cfg(o_cfg), .ep_din(o_din), .ep_re(ep_re),
    .ep_dout(ep_dout), .ep_we(ep_we), .ep_empty(o_empty), .ep_full(o_full), .ep_bf_en(o_bfen),
    .ep_bf_size(o_bfsz), .app_wdata(app_wdata), .app_we(app_we), .app_rdata(o_rdata), .app_re(app_re),
    .app_level(o_level), .err_ovf(o_ovf), .err_unf(o_unf), .err_clr(err_clr), .drop_cnt(o_drop));

  usb_ep_buf #(.DEPTH(DEPTH), .EP_CFG(14'h0400)) u_in (
    .clk(clk), .rst(rst), .flush(flush), .ep_cfg(i_cfg), .ep_din(i_din), .ep_re(ep_re),
    .ep_dout(ep_dout), .ep_we(ep_we), .ep_empty(i_empty), .ep_full(i_full), .ep_bf_en(i_bfen),
    .ep_bf_size(i_bfsz), .app_wdata(app_wdata), .app_we(app_we), .app_rdata(i_rdata), .app_re(app_re),
    .app_level(i_level), .err_ovf(i_ovf), .err_unf(i_unf), .err_clr(err_clr), .drop_cnt(i_drop));

  usb_ep_buf #(.DEPTH(DEPTH), .EP_CFG(14'h0000)) u_bad (
    .clk(clk), .rst(rst), .flush(flush), .ep_cfg(b_cfg), .ep_din(b_din), .ep_re(ep_re),
    .ep_dout(ep_dout), .ep_we(ep_we), .ep_empty(b_empty), .ep_full(b_full), .ep_bf_en(b_bfen),
    .ep_bf_size(b_bfsz), .app_wdata(app_wdata), .app_we(app_we), .app_rdata(b_rdata), .app_re(app_re),
    .app_level(b_level), .err_ovf(b_ovf), .err_unf(b_unf), .err_clr(err_clr), .drop_cnt(b_drop));

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  logic [7:0] qo[$], qi[$];

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_out(input int n, input bit ramp);
    for (int i = 0; i < n; i++) begin
      ep_we = 1;
      ep_dout = ramp ? 8'(i) : 8'($urandom);
      qo.push_back(ep_dout);
      tick;
      if (i == 0) chk("out_empty_after_first", o_empty, 0);
      if (i == n - 2 && n == DEPTH) chk("out_not_full_63", o_full, 0);
    end
    ep_we = 0;
  endtask

  task automatic drain_out(input int n);
    for (int i = 0; i < n; i++) begin
      chk("out_rdata", o_rdata, qo.pop_front());
      app_re = 1;
      tick;
    end
    app_re = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int mc;
    bit eu, eo, w, r, wa, ra;
    #12;
    chk("rst_out_empty", o_empty, 1);
    chk("rst_out_full", o_full, 0);
    chk("rst_out_bfsz", o_bfsz, DEPTH);
    chk("rst_out_level", o_level, 0);
    chk("rst_in_bfsz", i_bfsz, 0);
    chk("rst_bad_full", b_full, 1);
    chk("rst_bad_empty", b_empty, 1);
    chk("rst_out_ovf", o_ovf, 0);
    chk("rst_out_drop", o_drop, 0);
    chk("cfg_out", o_cfg, 14'h0800);
    chk("bfen_out", o_bfen, 1);
    @(posedge clk);
    #1 rst = 1;
    tick;

    // OUT ramp fill and drain
    fill_out(DEPTH, 1);
    chk("out_full", o_full, 1);
    chk("out_level_full", o_level, DEPTH);
    chk("out_bfsz_full", o_bfsz, 0);
    drain_out(DEPTH);
    chk("out_empty_drained", o_empty, 1);
    chk("out_level_drained", o_level, 0);
    chk("out_bfsz_drained", o_bfsz, DEPTH);
    chk("in_level_ignored", i_level, 0);
    chk("in_unf_ignored", i_unf, 0);
    chk("bad_level", b_level, 0);
    chk("bad_full_run", b_full, 1);
    chk("bad_unf", b_unf, 0);

    // IN: app writes 10, core reads 10
    for (int i = 0; i < 10; i++) begin
      app_we = 1;
      app_wdata = 8'($urandom);
      qi.push_back(app_wdata);
      tick;
      if (i == 0) begin
        chk("in_empty_first", i_empty, 0);
        chk("in_bfsz_first", i_bfsz, 1);
      end
    end
    app_we = 0;
    chk("in_bfsz_10", i_bfsz, 10);
    for (int i = 0; i < 10; i++) begin
      chk("in_din", i_din, qi.pop_front());
      ep_re = 1;
      tick;
    end
    ep_re = 0;
    chk("in_bfsz_0", i_bfsz, 0);
    chk("in_empty_0", i_empty, 1);
    chk("in_ovf_none", i_ovf, 0);
    chk("in_unf_none", i_unf, 0);
    chk("out_ovf_none", o_ovf, 0);
    chk("out_unf_none", o_unf, 0);

    // OUT overflow with simultaneous read
    fill_out(DEPTH, 0);
    chk("ovf_head", o_rdata, qo[0]);
    ep_we = 1;
    ep_dout = 8'hAA;
    app_re = 1;
    void'(qo.pop_front());
    tick;
    ep_we = 0;
    app_re = 0;
    chk("ovf_level", o_level, DEPTH - 1);
    chk("ovf_full", o_full, 0);
    chk("ovf_flag", o_ovf, ERR);
    chk("ovf_drop", o_drop, ERR);
    chk("ovf_bfsz", o_bfsz, 1);
    drain_out(DEPTH - 1);
    chk("ovf_drained", o_level, 0);

    // Underflow with simultaneous write, then err_clr against a new underflow
    app_re = 1;
    ep_we = 1;
    ep_dout = 8'h5C;
    tick;
    app_re = 0;
    ep_we = 0;
    chk("unf_level", o_level, 1);
    chk("unf_flag", o_unf, ERR);
    chk("unf_rdata", o_rdata, 8'h5C);
    chk("unf_empty", o_empty, 0);
    app_re = 1;
    tick;
    chk("unf_read_level", o_level, 0);
    err_clr = 1;
    tick;
    app_re = 0;
    err_clr = 0;
    chk("clr_unf_wins", o_unf, ERR);
    chk("clr_ovf", o_ovf, 0);
    chk("clr_drop", o_drop, 0);
    chk("clr_level", o_level, 0);

    // Random IN traffic against the scoreboard
    ep_re = 1;
    tick;
    ep_re = 0;
    mc = 0;
    eu = 1;
    eo = 0;
    for (int n = 0; n < 200; n++) begin
      w = $urandom_range(0, 99) < 60;
      r = $urandom_range(0, 99) < 45;
      if (qi.size() > 0) chk("rnd_din", i_din, qi[0]);
      app_we = w;
      app_wdata = 8'($urandom);
      ep_re = r;
      wa = w && mc < DEPTH;
      ra = r && mc > 0;
      if (r && mc == 0) eu = 1;
      if (w && mc == DEPTH) eo = 1;
      if (ra) void'(qi.pop_front());
      if (wa) qi.push_back(app_wdata);
      mc = mc + int'(wa) - int'(ra);
      tick;
      chk("rnd_level", i_level, mc);
      chk("rnd_empty", i_empty, int'(mc == 0));
    end
    ep_re = 0;
    chk("rnd_unf", i_unf, ERR & int'(eu));
    chk("rnd_ovf", i_ovf, ERR & int'(eo));

    // Flush mid-stream
    app_we = 1;
    flush = 1;
    tick;
    app_we = 0;
    flush = 0;
    qi.delete();
    chk("flush_level", i_level, 0);
    chk("flush_empty", i_empty, 1);
    chk("flush_bfsz", i_bfsz, 0);
    chk("flush_unf_kept", i_unf, ERR);

    // Asynchronous reset mid-write
    ep_we = 1;
    ep_dout = 8'h11;
    tick;
    tick;
    chk("prerst_level", o_level, 2);
    #2 rst = 0;
    #1;
    chk("arst_level", o_level, 0);
    chk("arst_empty", o_empty, 1);
    chk("arst_full", o_full, 0);
    chk("arst_bfsz", o_bfsz, DEPTH);
    chk("arst_unf", o_unf, 0);
    chk("arst_in_unf", i_unf, 0);
    ep_we = 0;
    @(posedge clk);
    #1 rst = 1;
    tick;
    chk("post_rst_level", o_level, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
